ula_result_bcd: RTL and testbench

ULA_RESULT_BCD -- requirements
Module: ula_result_bcd

---
 rtl/ula_pkg.sv | 23 ++
 rtl/bcd_add3.sv | 17 +
 rtl/ula_result_bcd.sv | 121 ++++++++++++
 tb/tb_ula_result_bcd.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ============================================================================
//  Module  : ula_pkg
//  Brief   : Shared state encoding and constants for the ALU result BCD converter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam logic [3:0] C_BLANK_CODE = 4'hF;
    localparam int         C_ITERATIONS = 8;
    localparam int         C_ITER_W     = $clog2(C_ITERATIONS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
//  Module  : bcd_add3
//  Brief   : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_add3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/ula_result_bcd.sv
// ============================================================================
//  Module  : ula_result_bcd
//  Brief   : Converts a signed 8-bit ALU result into sign + three BCD digits.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ula_result_bcd
    import ula_pkg::*;
#(
    parameter logic [3:0] BLANK_CODE = C_BLANK_CODE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_ula,
    input  logic       overflow,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       ovf_out
);

    state_t                r_state;
    logic [7:0]            r_data;
    logic                  r_ovf_cap;
    logic                  r_neg;
    logic [7:0]            r_mag;
    logic [9:0]            r_scratch;
    logic [C_ITER_W-1:0]   r_iter;

    logic [3:0]            w_units_adj;
    logic [3:0]            w_tens_adj;
    logic [3:0]            w_hund_adj;
    logic [9:0]            w_scratch_next;
    logic [7:0]            w_mag;
    logic                  w_unused_bits;

    bcd_add3 u_add3_units (.digit_in(r_scratch[3:0]),          .digit_out(w_units_adj));
    bcd_add3 u_add3_tens  (.digit_in(r_scratch[7:4]),          .digit_out(w_tens_adj));
    bcd_add3 u_add3_hund  (.digit_in({2'b00, r_scratch[9:8]}), .digit_out(w_hund_adj));

    // The scratch MSB shifted out is always zero for an 8-bit magnitude.
    assign w_scratch_next = {w_hund_adj[0], w_tens_adj, w_units_adj, r_mag[7]};
    assign w_unused_bits  = &{1'b0, w_hund_adj[3:1]};

    // -128 wraps to 8'h80, which is exactly the unsigned magnitude 128.
    assign w_mag = r_data[7] ? (~r_data + 8'd1) : r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_data    <= 8'd0;
            r_ovf_cap <= 1'b0;
            r_neg     <= 1'b0;
            r_mag     <= 8'd0;
            r_scratch <= 10'd0;
            r_iter    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign      <= 1'b0;
            bcd_hund  <= 4'h0;
            bcd_tens  <= 4'h0;
            bcd_units <= 4'h0;
            ovf_out   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        r_data    <= data_ula;
                        r_ovf_cap <= overflow;
                        busy      <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_mag     <= w_mag;
                    r_neg     <= r_data[7];
                    r_scratch <= 10'd0;
                    r_iter    <= '0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_mag     <= {r_mag[6:0], 1'b0};
                    r_iter    <= r_iter + 1'b1;
                    if (r_iter == C_ITER_W'(C_ITERATIONS - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                    if (r_ovf_cap) begin
                        sign      <= 1'b0;
                        bcd_hund  <= BLANK_CODE;
                        bcd_tens  <= BLANK_CODE;
                        bcd_units <= BLANK_CODE;
                        ovf_out   <= 1'b1;
                    end else begin
                        sign      <= r_neg;
                        bcd_hund  <= {2'b00, r_scratch[9:8]};
                        bcd_tens  <= r_scratch[7:4];
                        bcd_units <= r_scratch[3:0];
                        ovf_out   <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ula_result_bcd.sv
// ============================================================================
//  Module  : tb_ula_result_bcd
//  Brief   : Scoreboard bench for ula_result_bcd against a decimal reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ula_result_bcd;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_ula;
    logic       overflow;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       ovf_out;

    typedef struct {
        logic       sgn;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc      = 0;
    int   next_ok  = 0;
    int   last_acc = -100;
    int   vectors  = 0;
    int   fails    = 0;

    ula_result_bcd #(.BLANK_CODE(4'hF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_ula  (data_ula),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done),
        .sign      (sign),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_units (bcd_units),
        .ovf_out   (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t calc(input logic [7:0] d, input logic o, input int due);
        exp_t e;
        int   v;
        int   mag;
        v   = d[7] ? int'(d) - 256 : int'(d);
        mag = (v < 0) ? -v : v;
        e.due = due;
        if (o) begin
            e.sgn = 1'b0; e.h = 4'hF; e.t = 4'hF; e.u = 4'hF; e.ovf = 1'b1;
        end else begin
            e.sgn = (v < 0);
            e.h   = 4'(mag / 100);
            e.t   = 4'((mag / 10) % 10);
            e.u   = 4'(mag % 10);
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic void clear_held();
        held.sgn = 1'b0; held.h = 4'h0; held.t = 4'h0; held.u = 4'h0; held.ovf = 1'b0; held.due = 0;
    endfunction

    // Monitor: pops an expectation on every done pulse, otherwise checks held outputs.
    always @(negedge clk) begin
        exp_t e;
        chk("busy", 32'(busy), 32'((cyc >= last_acc) && (cyc <= last_acc + 9)));
        if (q.size() > 0 && !done && q[0].due < cyc) begin
            e = q.pop_front();
            chk("missing_done", 32'(done), 32'd1);
        end
        if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                chk("latency", 32'(cyc), 32'(e.due));
                held = e;
            end
        end
        chk("sign",  32'(sign),      32'(held.sgn));
        chk("hund",  32'(bcd_hund),  32'(held.h));
        chk("tens",  32'(bcd_tens),  32'(held.t));
        chk("units", 32'(bcd_units), 32'(held.u));
        chk("ovf",   32'(ovf_out),   32'(held.ovf));
    end

    task automatic drive(input logic s, input logic [7:0] d, input logic o);
        @(negedge clk);
        #1;
        start    = s;
        data_ula = d;
        overflow = o;
        if (s && rst_n && (cyc + 1) >= next_ok) begin
            q.push_back(calc(d, o, cyc + 11));
            last_acc = cyc + 1;
            next_ok  = cyc + 13;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        start    = 1'b0;
        q.delete();
        clear_held();
        last_acc = -100;
        next_ok  = 0;
        #1;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_sign",  32'(sign),      32'd0);
        chk("rst_hund",  32'(bcd_hund),  32'd0);
        chk("rst_tens",  32'(bcd_tens),  32'd0);
        chk("rst_units", 32'(bcd_units), 32'd0);
        chk("rst_ovf",   32'(ovf_out),   32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_held();
        rst_n    = 1'b0;
        start    = 1'b0;
        data_ula = 8'd0;
        overflow = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        drive(1'b1, 8'd127, 1'b0); idle(13);
        drive(1'b1, 8'h80,  1'b0); idle(13);
        drive(1'b1, 8'h00,  1'b0); idle(13);
        drive(1'b1, 8'h80,  1'b1); idle(13);

        // Start while busy must be ignored; outputs then hold.
        drive(1'b1, 8'hFB, 1'b0); idle(3);
        drive(1'b1, 8'd99, 1'b0); idle(25);

        // Continuous start: requests during busy and the done cycle are dropped.
        for (int i = 0; i < 30; i++) drive(1'b1, 8'($urandom), 1'($urandom_range(0, 5) == 0));
        idle(14);

        // Abort mid-conversion, then a fresh conversion right after release.
        drive(1'b1, 8'd77, 1'b0); idle(3);
        do_reset();
        drive(1'b1, 8'd42, 1'b0); idle(13);

        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 7) == 0));
        drive(1'b0, 8'd0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
